// File: rtl/display_scan_ctrl_pkg.sv
// Shared seven-segment constants and slot record for the display scan controller.
// All segment and anode values are active-low.
package display_pkg;

  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef struct packed {
    logic [3:0] code;
    logic       blink;
  } slot_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Slot write bus from floor logic into the display scan controller.
interface display_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_code;
  logic       wr_blink;

  modport master (output wr_en, output wr_idx, output wr_code, output wr_blink);
  modport slave  (input  wr_en, input  wr_idx, input  wr_code, input  wr_blink);
endinterface

// File: rtl/display_scan_ctrl_seg_decode.sv
// One-hot floor code to active-low segment pattern; non-one-hot codes show a dash.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'b0000: seg = SEG_BLANK;
      4'b0001: seg = SEG_1;
      4'b0010: seg = SEG_2;
      4'b0100: seg = SEG_3;
      4'b1000: seg = SEG_4;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scanner with frame-synchronous
// content latching, inter-digit blanking and internally timed blinking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_ctrl_if.slave   wr,
  output logic [6:0]           seg,
  output logic [3:0]           an,
  output logic                 frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       dig_reg;
  logic [FC_W-1:0]  fc_reg;
  logic             blink_phase_reg;
  logic             first_reg;
  slot_state_e      state_reg, state_next;

  slot_t [3:0]      shadow_reg;
  slot_t [3:0]      active_reg;

  logic [6:0]       seg_reg, seg_next;
  logic [3:0]       an_reg, an_next;
  logic             frame_start_reg;

  logic [3:0][6:0]  slot_seg;
  logic             slot_last;
  logic             frame_go;

  assign slot_last = (cnt_reg == CNT_LAST);
  // The very first edge after reset also opens a frame so content latches immediately.
  assign frame_go  = first_reg | (slot_last & (dig_reg == 2'd3));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      seg_decode u_seg_decode (
        .code (active_reg[gi].code),
        .seg  (slot_seg[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      dig_reg         <= '0;
      fc_reg          <= '0;
      blink_phase_reg <= 1'b0;
      first_reg       <= 1'b1;
      state_reg       <= ST_BLANK;
      shadow_reg      <= '0;
      active_reg      <= '0;
      seg_reg         <= SEG_BLANK;
      an_reg          <= AN_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      first_reg       <= 1'b0;
      state_reg       <= state_next;
      seg_reg         <= seg_next;
      an_reg          <= an_next;
      frame_start_reg <= frame_go;

      cnt_reg <= slot_last ? '0 : cnt_reg + CNT_W'(1);
      if (slot_last) begin
        dig_reg <= dig_reg + 2'd1;
      end

      if (frame_go) begin
        // Copy takes the pre-edge shadow; a write on this same edge waits a frame.
        active_reg <= shadow_reg;
        if (fc_reg == FC_LAST) begin
          fc_reg          <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          fc_reg <= fc_reg + FC_W'(1);
        end
      end

      if (wr.wr_en) begin
        shadow_reg[wr.wr_idx] <= '{code: wr.wr_code, blink: wr.wr_blink};
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    an_next    = AN_OFF;
    seg_next   = SEG_BLANK;

    case (state_reg)
      ST_BLANK: if (cnt_reg == BLANK_LAST) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_last)             state_next = ST_BLANK;
      default:                             state_next = ST_BLANK;
    endcase

    // A blinking slot in its off phase stays blank for the entire slot.
    if ((state_reg == ST_DRIVE) && !(active_reg[dig_reg].blink && blink_phase_reg)) begin
      an_next  = ~(4'b0001 << dig_reg);
      seg_next = slot_seg[dig_reg];
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-indexed reference model queues
// expected outputs, a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

  localparam int SD    = 16;
  localparam int BC    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_start;

  display_scan_ctrl_if wr_bus ();

  display_scan_ctrl #(
    .SCAN_DIV     (SD),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr_bus),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: edges since reset, frames opened, shadow/active banks.
  int         edge_no = 0;
  int         frames_started = 0;
  logic [3:0] sh_code [4];
  logic       sh_blink[4];
  logic [3:0] ac_code [4];
  logic       ac_blink[4];
  int         m_s, m_cnt, m_dig;
  logic       m_phase, m_copy;
  exp_t       m_x, mon_x;

  function automatic logic [6:0] ref_seg(input logic [3:0] code);
    case (code)
      4'b0000: return 7'b1111111;
      4'b0001: return 7'b1001111;
      4'b0010: return 7'b0010010;
      4'b0100: return 7'b0000110;
      4'b1000: return 7'b1001100;
      default: return 7'b1111110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, req, edge_no, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_no        = 0;
      frames_started = 0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
        sh_code[i] = 4'b0; sh_blink[i] = 1'b0;
        ac_code[i] = 4'b0; ac_blink[i] = 1'b0;
      end
    end else begin
      edge_no++;
      m_s     = edge_no - 1;
      m_cnt   = m_s % SD;
      m_dig   = (m_s / SD) % 4;
      m_phase = ((frames_started / BF) % 2) == 1;
      m_x.an  = 4'hF;
      m_x.seg = 7'h7F;
      if (!(m_cnt < BC || (ac_blink[m_dig] && m_phase))) begin
        m_x.an[m_dig] = 1'b0;
        m_x.seg       = ref_seg(ac_code[m_dig]);
      end
      m_copy = (edge_no == 1) || (edge_no % FRAME == 0);
      m_x.fs = m_copy;
      exp_q.push_back(m_x);
      if (m_copy) begin
        for (int i = 0; i < 4; i++) begin
          ac_code[i]  = sh_code[i];
          ac_blink[i] = sh_blink[i];
        end
        frames_started++;
      end
      if (wr_bus.wr_en) begin
        sh_code[wr_bus.wr_idx]  = wr_bus.wr_code;
        sh_blink[wr_bus.wr_idx] = wr_bus.wr_blink;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || exp_q.size() == 0) begin
      check("reset_an",  an,          4'hF);
      check("reset_seg", seg,         7'h7F);
      check("reset_fs",  frame_start, 1'b0);
    end else begin
      mon_x = exp_q.pop_front();
      check("an",          an,          mon_x.an);
      check("seg",         seg,         mon_x.seg);
      check("frame_start", frame_start, mon_x.fs);
    end
    check("one_anode", ($countones(~an) <= 1), 1);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int idx, input logic [3:0] code, input logic bl);
    @(negedge clk);
    if ((edge_no + 1) % FRAME == 0) @(negedge clk);
    wr_bus.wr_en    = 1'b1;
    wr_bus.wr_idx   = 2'(idx);
    wr_bus.wr_code  = code;
    wr_bus.wr_blink = bl;
    @(negedge clk);
    wr_bus.wr_en    = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    int budget;
    budget = 2 * FRAME;
    while ((edge_no % FRAME) != pos && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_pos_timeout", budget > 0, 1);
  endtask

  int e0;

  initial begin
    wr_bus.wr_en    = 1'b0;
    wr_bus.wr_idx   = 2'd0;
    wr_bus.wr_code  = 4'd0;
    wr_bus.wr_blink = 1'b0;
    rst_n = 1'b0;
    run(3);
    @(posedge clk); #2 rst_n = 1'b1;

    run(3 * FRAME);                       // idle: blank, frame_start every frame

    wait_pos(20);
    write(2, 4'b0100, 1'b0);              // mid-frame: shows only next frame
    run(2 * FRAME);

    write(0, 4'b0001, 1'b0);
    write(1, 4'b0010, 1'b0);
    write(2, 4'b0100, 1'b0);
    write(3, 4'b1000, 1'b0);
    run(2 * FRAME);

    write(0, 4'b0011, 1'b0);              // not one-hot: dash
    run(2 * FRAME);

    write(1, 4'b0010, 1'b1);              // blinking slot
    run(9 * FRAME);

    repeat (60) begin
      write($urandom_range(0, 3), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0));
      run($urandom_range(1, 40));
    end

    write(3, 4'b0000, 1'b0);
    run(FRAME + 5);
    wait_pos(0);                          // cycle right after a frame-start edge
    check("fs_cycle", frame_start, 1'b1);
    e0 = edge_no;
    wr_bus.wr_en    = 1'b1;
    wr_bus.wr_idx   = 2'd3;
    wr_bus.wr_code  = 4'b1000;
    wr_bus.wr_blink = 1'b0;
    @(negedge clk);
    wr_bus.wr_en    = 1'b0;
    while (edge_no < e0 + FRAME + 3 * SD + 9) @(negedge clk);
    check("late_write_an",  an,  4'b0111);
    check("late_write_seg", seg, 7'b1001100);

    @(posedge clk); #2 rst_n = 1'b0;      // mid-drive reset
    #1;
    check("async_rst_an",  an,          4'hF);
    check("async_rst_seg", seg,         7'h7F);
    check("async_rst_fs",  frame_start, 1'b0);
    run(3);
    @(posedge clk); #2 rst_n = 1'b1;
    run(2 * FRAME + 10);                  // banks cleared: display stays blank

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
